// File: rtl/fsm_req_arbiter.sv
// Round-robin share of one FSM among N_REQ requesters; result 1 cycle after each consumed RUN cycle, no backpressure.
// Optional: define FSM_ARB_PRIO_EN to give requester 0 strict priority at arbitration.
module fsm_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 8,
  parameter int VEC_W     = 3,
  parameter int OUT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           last,
  input  logic [N_REQ*VEC_W-1:0]     vec_in,
  output logic [N_REQ-1:0]           gnt,
  output logic [VEC_W-1:0]           fsm_in,
  output logic                       fsm_rst,
  input  logic [OUT_W-1:0]           fsm_out,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [OUT_W-1:0]           rsp_data,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, RST_FSM, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   owner, ptr, pick, ptr_nxt;
  logic              pick_vld;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              owner_req, owner_last, consume, run_act;
  logic [VEC_W-1:0]  owner_vec;
  int                d, best_d;
`ifdef FSM_ARB_PRIO_EN
  int                base;
`endif

  // Winner is the requester at the smallest rotational distance from ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    d        = 0;
    best_d   = N_REQ;
`ifdef FSM_ARB_PRIO_EN
    base = (ptr == '0) ? 1 : int'(ptr);
    for (int i = 1; i < N_REQ; i++) begin
      d = (i - base + N_REQ - 1) % (N_REQ - 1);
      if (req[i] && d < best_d) begin
        best_d   = d;
        pick     = ID_W'(i);
        pick_vld = 1'b1;
      end
    end
    if (req[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - int'(ptr)) % N_REQ;
      if (req[i] && d < best_d) begin
        best_d   = d;
        pick     = ID_W'(i);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    owner_vec  = '0;
    owner_req  = 1'b0;
    owner_last = 1'b0;
    run_act    = (state == RUN) && !rst_b;
    gnt        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_vec  = vec_in[i*VEC_W +: VEC_W];
        owner_req  = req[i];
        owner_last = last[i];
      end
      gnt[i] = run_act && (owner == ID_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    fsm_in    = '0;
    consume   = (state == RUN) && owner_req;
    cnt_inc   = cnt + CNT_W'(1);
    ptr_nxt   = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);
    case (state)
      IDLE:    if (pick_vld) state_nxt = RST_FSM;
      RST_FSM: state_nxt = RUN;
      RUN: begin
        if (run_act) fsm_in = owner_vec;
        // Dropping req aborts without consuming; last and the burst limit may coincide.
        if (!owner_req || owner_last || cnt_inc == CNT_W'(BURST_MAX))
          state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= consume;
      if (consume) begin
        rsp_data <= fsm_out;
        rsp_id   <= owner;
        cnt      <= cnt_inc;
      end
      if (state == IDLE) begin
        cnt <= '0;
        if (pick_vld) owner <= pick;
      end
      if (state == DRAIN) ptr <= ptr_nxt;
    end
  end

  assign fsm_rst = rst_b || (state == RST_FSM);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fsm_req_arbiter.sv
// Bench for fsm_req_arbiter: scripted requesters, a counting stand-in FSM, and a response scoreboard.
module tb_fsm_req_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  logic        clk, rst_b;
  logic [3:0]  req, last, gnt;
  logic [11:0] vec_in;
  logic [2:0]  fsm_in;
  logic        fsm_rst;
  logic [3:0]  fsm_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        busy;
  logic [3:0]  acc;

  fsm_req_arbiter #(.N_REQ(4), .BURST_MAX(8), .VEC_W(3), .OUT_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .last(last), .vec_in(vec_in),
    .gnt(gnt), .fsm_in(fsm_in), .fsm_rst(fsm_rst), .fsm_out(fsm_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in FSM: output = input + cycles since its last reset.
  always @(posedge clk) acc <= fsm_rst ? 4'd0 : acc + 4'd1;
  assign fsm_out = {1'b0, fsm_in} + acc;

  exp_t        sbq[$];
  int          errors, checks, rsp_seen;
  logic [2:0]  vtab [4][32];
  int          pos[4], drop_at[4], last_at[4];
  logic [3:0]  en;
  logic        rst_req;
  int          run_k, gap_cnt, blen_cur;
  logic [3:0]  prev_gnt;
  int          glog[$], gaps[$], blens[$];
  int          rsp_base;
  bit          found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic int gl(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  function automatic int bl(input int i);
    if (i < blens.size()) return blens[i];
    return -1;
  endfunction

  function automatic int gp(input int i);
    if (i < gaps.size()) return gaps[i];
    return -1;
  endfunction

  // Drive one cycle at the falling edge; predict consumption for the coming rising edge.
  task automatic step();
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    rst_b = rst_req;
    for (int i = 0; i < 4; i++) begin
      req[i]  = en[i] && (pos[i] < drop_at[i]);
      last[i] = (pos[i] == last_at[i]);
      vec_in[i*3 +: 3] = vtab[i][pos[i] % 32];
    end
    #1;
    if (gnt != 4'd0) begin
      k = run_k;
      run_k++;
      if (prev_gnt == 4'd0) begin
        glog.push_back(oh_idx(gnt));
        gaps.push_back(gap_cnt);
        blen_cur = 0;
      end
      blen_cur++;
    end else begin
      run_k = 0;
      if (prev_gnt != 4'd0) begin
        blens.push_back(blen_cur);
        gap_cnt = 0;
      end
      gap_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      if (gnt[i] && req[i]) begin
        e.id   = 2'(i);
        e.data = 4'({1'b0, vtab[i][pos[i] % 32]} + k);
        sbq.push_back(e);
        pos[i]++;
      end
    end
    prev_gnt = gnt;
  endtask

  task automatic run_grants(input int n, input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (glog.size() >= n && busy === 1'b0 && gnt === 4'd0) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int order[5];
    errors = 0; checks = 0; rsp_seen = 0;
    run_k = 0; gap_cnt = 0; blen_cur = 0; prev_gnt = 4'd0;
    rst_b = 1'b1; rst_req = 1'b1; req = 4'd0; last = 4'd0; vec_in = 12'd0;
    en = 4'b1111;
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 32; p++) vtab[i][p] = 3'(i*3 + p*5 + 1);
    for (int i = 0; i < 4; i++) begin
      pos[i] = 0; drop_at[i] = 8; last_at[i] = 99;
    end
    drop_at[0] = 16;
    last_at[3] = 7;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rsp_valid === 1'b1) begin
            rsp_seen++;
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected: got id=%0d data=%0h, required no response", rsp_id, rsp_data);
            end else begin
              e = sbq.pop_front();
              chk("rsp_id", 32'(rsp_id), 32'(e.id));
              chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
          end
        end
      end
    join_none

    // Reset held with all requesters asking.
    repeat (2) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fsm_rst", 32'(fsm_rst), 32'd1);
      chk("rst_fsm_in", 32'(fsm_in), 32'd0);
    end
    rst_req = 1'b0;
    glog.delete(); gaps.delete(); blens.delete();
    rsp_base = rsp_seen;
    step();
    chk("idle_fsm_rst", 32'(fsm_rst), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Saturation: 0,1,2,3,0 with full bursts; requester 3 ends with last on its 8th vector.
    run_grants(5, 400, "sat");
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sat_grant%0d", k), 32'(gl(k)), 32'(order[k]));
      chk($sformatf("sat_len%0d", k), 32'(bl(k)), 32'd8);
      if (k > 0) chk($sformatf("sat_gap%0d", k), 32'(gp(k)), 32'd3);
    end
    chk("sat_rsp_count", 32'(rsp_seen - rsp_base), 32'd40);

    // Single burst from requester 2: 011,111,001 with last on 001.
    for (int i = 0; i < 4; i++) pos[i] = 0;
    vtab[2][0] = 3'b011; vtab[2][1] = 3'b111; vtab[2][2] = 3'b001;
    last_at[2] = 2; drop_at[2] = 3; en = 4'b0100;
    step();
    chk("sb_t_busy", 32'(busy), 32'd0);
    step();
    chk("sb_t1_fsm_rst", 32'(fsm_rst), 32'd1);
    chk("sb_t1_gnt", 32'(gnt), 32'd0);
    step();
    chk("sb_t2_gnt", 32'(gnt), 32'b0100);
    chk("sb_t2_fsm_in", 32'(fsm_in), 32'b011);
    chk("sb_t2_fsm_rst", 32'(fsm_rst), 32'd0);
    chk("sb_t2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("sb_t3_fsm_in", 32'(fsm_in), 32'b111);
    chk("sb_t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sb_t3_rsp_id", 32'(rsp_id), 32'd2);
    chk("sb_t3_rsp_data", 32'(rsp_data), 32'd3);
    step();
    chk("sb_t4_gnt", 32'(gnt), 32'b0100);
    chk("sb_t4_fsm_in", 32'(fsm_in), 32'b001);
    chk("sb_t4_rsp_data", 32'(rsp_data), 32'd8);
    step();
    chk("sb_t5_gnt", 32'(gnt), 32'd0);
    chk("sb_t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sb_t5_rsp_data", 32'(rsp_data), 32'd3);
    step();
    chk("sb_t6_busy", 32'(busy), 32'd0);
    chk("sb_t6_rsp_valid", 32'(rsp_valid), 32'd0);

    // Abort: requester 1 drops req in its second RUN cycle.
    pos[1] = 0; drop_at[1] = 1; last_at[1] = 99; en = 4'b0010;
    repeat (3) step();
    chk("ab_run0_gnt", 32'(gnt), 32'b0010);
    step();
    chk("ab_run1_gnt", 32'(gnt), 32'b0010);
    chk("ab_run1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ab_run1_rsp_data", 32'(rsp_data), 32'd4);
    step();
    chk("ab_drain_gnt", 32'(gnt), 32'd0);
    chk("ab_drain_busy", 32'(busy), 32'd1);
    chk("ab_drain_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("ab_idle_busy", 32'(busy), 32'd0);
    pos[0] = 0; pos[1] = 0; drop_at[0] = 2; drop_at[1] = 2;
    last_at[0] = 1; last_at[1] = 1; en = 4'b0011;
    glog.delete();
    run_grants(2, 100, "ab_next");
    chk("ab_next_grant0", 32'(gl(0)), 32'd0);
    chk("ab_next_grant1", 32'(gl(1)), 32'd1);

    // Reset in the middle of requester 3's burst.
    pos[3] = 0; drop_at[3] = 99; last_at[3] = 99; en = 4'b1000;
    glog.delete();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt === 4'b1000) begin
        found = 1'b1;
        break;
      end
    end
    chk("mr_granted", 32'(found), 32'd1);
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0; en = 4'b0000;
    step();
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    pos[0] = 0; pos[2] = 0; drop_at[0] = 1; drop_at[2] = 1;
    last_at[0] = 0; last_at[2] = 0; en = 4'b0101;
    glog.delete();
    run_grants(2, 100, "mr_next");
    chk("mr_next_grant0", 32'(gl(0)), 32'd0);
    chk("mr_next_grant1", 32'(gl(1)), 32'd2);

    // Bring ptr to 2, then all but requester 1 ask at once.
    pos[1] = 0; drop_at[1] = 1; last_at[1] = 0; en = 4'b0010;
    glog.delete();
    run_grants(1, 50, "pre_prio");
    chk("pre_prio_grant", 32'(gl(0)), 32'd1);
    pos[0] = 0; pos[2] = 0; pos[3] = 0;
    drop_at[0] = 1; drop_at[2] = 1; drop_at[3] = 1;
    last_at[0] = 0; last_at[2] = 0; last_at[3] = 0;
    en = 4'b1101;
    glog.delete();
    run_grants(3, 100, "prio");
`ifdef FSM_ARB_PRIO_EN
    chk("prio_grant0", 32'(gl(0)), 32'd0);
    chk("prio_grant1", 32'(gl(1)), 32'd2);
    chk("prio_grant2", 32'(gl(2)), 32'd3);
`else
    chk("prio_grant0", 32'(gl(0)), 32'd2);
    chk("prio_grant1", 32'(gl(1)), 32'd3);
    chk("prio_grant2", 32'(gl(2)), 32'd0);
`endif

    en = 4'b0000;
    repeat (3) step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
